// File: rtl/agg_pkg.sv
// Shared constants and helpers for the SGM path-aggregation and WTA stages.
package agg_pkg;

  localparam int DISP = 96;   // disparities per pixel
  localparam int CW   = 9;    // initial cost width
  localparam int AW   = 11;   // aggregated cost width
  localparam int P1   = 10;   // penalty for a +/-1 disparity step
  localparam int P2   = 120;  // penalty for any larger step

  // Cost-vector widths for the default configuration.
  localparam int CVEC_W = DISP * CW;
  localparam int LVEC_W = DISP * AW;

  // Clamp an unsigned value to the largest value representable in aw bits.
  function automatic logic [31:0] sat_aw(input logic [31:0] x, input int unsigned aw);
    logic [31:0] lim;
    lim = (32'd1 << aw) - 32'd1;
    return (x > lim) ? lim : x;
  endfunction

endpackage

// File: rtl/min_tree.sv
// Combinational binary-tree minimum over N unsigned values of W bits each.
// Inputs are padded to a power of two with all-ones so padding never wins.
module min_tree #(
  parameter int N = 96,
  parameter int W = 11
) (
  input  logic [N*W-1:0] data_i,
  output logic [W-1:0]   min_o
);

  localparam int LV = (N > 1) ? $clog2(N) : 0;
  localparam int NP = 1 << LV;

  genvar gl, gi;
  generate
    for (gl = 0; gl <= LV; gl++) begin : g_lvl
      logic [W-1:0] v [NP >> gl];
      if (gl == 0) begin : g_leaf
        for (gi = 0; gi < NP; gi++) begin : g_n
          if (gi < N) begin : g_in
            assign v[gi] = data_i[gi*W +: W];
          end else begin : g_pad
            assign v[gi] = '1;
          end
        end
      end else begin : g_node
        for (gi = 0; gi < (NP >> gl); gi++) begin : g_n
          assign v[gi] = (g_lvl[gl-1].v[2*gi] <= g_lvl[gl-1].v[2*gi+1])
                         ? g_lvl[gl-1].v[2*gi] : g_lvl[gl-1].v[2*gi+1];
        end
      end
    end
  endgenerate

  assign min_o = g_lvl[LV].v[0];

endmodule

// File: rtl/path_aggregate_lr.sv
// Left-to-right SGM path-cost aggregation: one pixel per cycle, Lr recurrence
// closes in a single cycle through the min tree over the previous pixel.
module path_aggregate_lr #(
  parameter int IMG_ROW = 200,
  parameter int IMG_COL = 400,
  parameter int DISP    = agg_pkg::DISP,
  parameter int CW      = agg_pkg::CW,
  parameter int AW      = agg_pkg::AW,
  parameter int P1      = agg_pkg::P1,
  parameter int P2      = agg_pkg::P2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DISP*CW-1:0]   data_in,
  output logic [DISP*AW-1:0]   data_out,
  output logic [AW-1:0]        min_out,
  output logic                 valid,
  output logic                 frame_done
);
  import agg_pkg::*;

  localparam int COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int ROW_W = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW - 1);

  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DISP*AW-1:0] lr_q, lr_d;
  logic [AW-1:0]      mprev;
  logic               valid_q, frame_done_q;
  logic               col_last, row_last;

  // Minimum of the previous pixel's Lr; also the registered pixel's min_out.
  min_tree #(.N(DISP), .W(AW)) u_min_tree (
    .data_i (lr_q),
    .min_o  (mprev)
  );

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // Raster position of the next accepted pixel.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_last) begin
      col_d = '0;
      row_d = row_last ? '0 : row_q + 1'b1;
    end
  end

  // Per-disparity update cell: Lr = C + min(neighbourhood) - mprev, or a
  // plain restart from C at the first column of every row.
  genvar gi;
  generate
    for (gi = 0; gi < DISP; gi++) begin : g_cell
      logic [AW:0] self_c, left_c, right_c, jump_c;
      logic [AW:0] t_a, t_b, t_min, c_ext, sum;

      assign self_c = {1'b0, lr_q[gi*AW +: AW]};
      assign jump_c = {1'b0, mprev} + (AW+1)'(P2);

      if (gi > 0) begin : g_left
        assign left_c = {1'b0, lr_q[(gi-1)*AW +: AW]} + (AW+1)'(P1);
      end else begin : g_no_left
        assign left_c = '1;
      end

      if (gi < DISP - 1) begin : g_right
        assign right_c = {1'b0, lr_q[(gi+1)*AW +: AW]} + (AW+1)'(P1);
      end else begin : g_no_right
        assign right_c = '1;
      end

      assign t_a   = (self_c  <= left_c) ? self_c  : left_c;
      assign t_b   = (right_c <= jump_c) ? right_c : jump_c;
      assign t_min = (t_a     <= t_b)    ? t_a     : t_b;

      // Subtract mprev first: t - mprev is bounded by P2, so the sum with C
      // stays inside AW+1 bits even for narrow AW.
      assign c_ext = (AW+1)'(data_in[gi*CW +: CW]);
      assign sum   = c_ext + (t_min - {1'b0, mprev});

      assign lr_d[gi*AW +: AW] = (col_q == '0)
          ? AW'(sat_aw(32'(data_in[gi*CW +: CW]), AW))
          : AW'(sat_aw(32'(sum), AW));
    end
  endgenerate

  // Lr bank, counters and output strobes; everything holds while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_q      <= en;
      frame_done_q <= en & col_last & row_last;
      if (en) begin
        lr_q  <= lr_d;
        col_q <= col_d;
        row_q <= row_d;
      end
    end
  end

  assign data_out   = lr_q;
  assign min_out    = mprev;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_path_aggregate_lr.sv
// Self-checking bench for path_aggregate_lr: a small frame (4x2) at AW=11 and
// a parallel AW=9 instance sharing the same stimulus for saturation.
module tb_path_aggregate_lr;

  localparam int ND   = 96;
  localparam int NCOL = 4;
  localparam int NROW = 2;
  localparam int VW   = 1056;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en  = 1'b0;
  logic [863:0]   data_in = '0;
  logic [1055:0]  dout_a;
  logic [10:0]    min_a;
  logic           valid_a, fd_a;
  logic [863:0]   dout_b;
  logic [8:0]     min_b;
  logic           valid_b, fd_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state: index 0 -> AW=11, index 1 -> AW=9.
  int lrs [2][ND];
  int mcol, mrow;
  bit exp_fd;

  always #5 clk = ~clk;

  path_aggregate_lr #(.IMG_ROW(NROW), .IMG_COL(NCOL)) dut_a (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .data_out(dout_a), .min_out(min_a), .valid(valid_a), .frame_done(fd_a)
  );

  path_aggregate_lr #(.IMG_ROW(NROW), .IMG_COL(NCOL), .AW(9)) dut_b (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .data_out(dout_b), .min_out(min_b), .valid(valid_b), .frame_done(fd_b)
  );

  function automatic int aw_of(input int k);
    return (k == 0) ? 11 : 9;
  endfunction

  function automatic logic [1055:0] pack(input int k);
    logic [1055:0] v;
    v = '0;
    for (int d = 0; d < ND; d++)
      v = v | (VW'(lrs[k][d]) << (d * aw_of(k)));
    return v;
  endfunction

  function automatic int model_min(input int k);
    int m;
    m = lrs[k][0];
    for (int d = 1; d < ND; d++) if (lrs[k][d] < m) m = lrs[k][d];
    return m;
  endfunction

  function automatic logic [863:0] rand_cost();
    logic [863:0] v;
    for (int d = 0; d < ND; d++) v[d*9 +: 9] = 9'($urandom_range(0, 511));
    return v;
  endfunction

  function automatic logic [863:0] fill_cost(input int val);
    logic [863:0] v;
    for (int d = 0; d < ND; d++) v[d*9 +: 9] = 9'(val);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int d = 0; d < ND; d++) lrs[k][d] = 0;
    mcol   = 0;
    mrow   = 0;
    exp_fd = 1'b0;
  endtask

  // SGM recurrence from the algorithm's definition, with plain integers.
  task automatic model_step(input logic [863:0] c);
    int cc [ND];
    int nl [ND];
    int lim, m, t, v;
    for (int d = 0; d < ND; d++) cc[d] = int'(c[d*9 +: 9]);
    for (int k = 0; k < 2; k++) begin
      lim = (1 << aw_of(k)) - 1;
      m   = model_min(k);
      for (int d = 0; d < ND; d++) begin
        if (mcol == 0) begin
          v = cc[d];
        end else begin
          t = lrs[k][d];
          if (d > 0 && lrs[k][d-1] + 10 < t) t = lrs[k][d-1] + 10;
          if (d < ND - 1 && lrs[k][d+1] + 10 < t) t = lrs[k][d+1] + 10;
          if (m + 120 < t) t = m + 120;
          v = cc[d] + t - m;
        end
        nl[d] = (v > lim) ? lim : v;
      end
      for (int d = 0; d < ND; d++) lrs[k][d] = nl[d];
    end
    exp_fd = (mcol == NCOL - 1) && (mrow == NROW - 1);
    if (mcol == NCOL - 1) begin
      mcol = 0;
      mrow = (mrow == NROW - 1) ? 0 : mrow + 1;
    end else begin
      mcol = mcol + 1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [1055:0] obs,
                         input logic [1055:0] exp, input int aw);
    int bad;
    logic [1055:0] mask;
    checks++;
    assert (obs === exp) else begin
      failures++;
      bad  = 0;
      mask = (VW'(1) << aw) - VW'(1);
      for (int d = ND - 1; d >= 0; d--)
        if (((obs >> (d*aw)) & mask) !== ((exp >> (d*aw)) & mask)) bad = d;
      $error("FAIL %s first_bad_d=%0d observed=%0d expected=%0d", tag, bad,
             int'((obs >> (bad*aw)) & mask), int'((exp >> (bad*aw)) & mask));
    end
  endtask

  task automatic check_outputs(input bit ev, input bit efd, input string tag);
    chk_vec({tag, "_dout_a"}, dout_a, pack(0), 11);
    chk({tag, "_min_a"}, int'(min_a), model_min(0));
    chk({tag, "_valid"}, int'(valid_a), int'(ev));
    chk({tag, "_frame_done"}, int'(fd_a), int'(efd));
    chk_vec({tag, "_dout_b"}, VW'(dout_b), pack(1), 9);
    chk({tag, "_min_b"}, int'(min_b), model_min(1));
    $display("pixel %s valid=%0b frame_done=%0b min_a=%0d min_b=%0d",
             tag, valid_a, fd_a, min_a, min_b);
  endtask

  task automatic send(input logic [863:0] c, input string tag);
    @(negedge clk);
    data_in = c;
    en      = 1'b1;
    model_step(c);
    @(posedge clk);
    #1;
    en = 1'b0;
    check_outputs(1'b1, exp_fd, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in = rand_cost();
      @(posedge clk);
      #1;
      check_outputs(1'b0, 1'b0, "idle");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs(1'b0, 1'b0, "async_reset");
    @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b0, "reset_hold");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [863:0]  c;
    logic [1055:0] ev;

    // Reset held with traffic present: outputs must stay cleared.
    model_reset();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_in = rand_cost();
      @(posedge clk);
      #1;
      check_outputs(1'b0, 1'b0, "reset_en");
    end
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;

    // Column 0 passes the cost straight through.
    c = fill_cost(5);
    c[3*9 +: 9] = 9'd2;
    send(c, "pass_col0");
    chk("pass_d3", int'(dout_a[3*11 +: 11]), 2);
    chk("pass_d0", int'(dout_a[0 +: 11]), 5);
    chk("pass_min", int'(min_a), 2);

    // Flat costs: Lr at column 1 equals C.
    do_reset();
    send(fill_cost(10), "flat_col0");
    send(fill_cost(7), "flat_col1");
    chk("flat_min", int'(min_a), 7);

    // Penalty shape around a single zero.
    do_reset();
    c = fill_cost(200);
    c[40*9 +: 9] = 9'd0;
    send(c, "pen_col0");
    send(fill_cost(0), "pen_col1");
    chk("pen_d40", int'(dout_a[40*11 +: 11]), 0);
    chk("pen_d39", int'(dout_a[39*11 +: 11]), 10);
    chk("pen_d41", int'(dout_a[41*11 +: 11]), 10);
    chk("pen_d0", int'(dout_a[0 +: 11]), 120);

    // Same, with a 5-cycle gap between the two pixels.
    do_reset();
    send(c, "stall_col0");
    idle(5);
    send(fill_cost(0), "stall_col1");
    chk("stall_d39", int'(dout_a[39*11 +: 11]), 10);
    chk("stall_d95", int'(dout_a[95*11 +: 11]), 120);

    // Frame wrap: frame_done on the 8th pixel, 9th restarts from C.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      c = rand_cost();
      send(c, $sformatf("frame_p%0d", i));
    end
    ev = '0;
    for (int d = 0; d < ND; d++) ev[d*11 +: 11] = 11'(c[d*9 +: 9]);
    chk_vec("frame_restart", dout_a, ev, 11);

    // Saturation at AW=9 versus the unclamped AW=11 value.
    do_reset();
    c = fill_cost(511);
    c[50*9 +: 9] = 9'd0;
    send(c, "sat_col0");
    send(fill_cost(511), "sat_col1");
    chk("sat_b_d0", int'(dout_b[0 +: 9]), 511);
    chk("sat_a_d0", int'(dout_a[0 +: 11]), 631);
    chk("sat_a_d49", int'(dout_a[49*11 +: 11]), 521);

    // Random traffic with random gaps and a mid-frame reset.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      if (i == 21) do_reset();
      send(rand_cost(), $sformatf("rand_p%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
